udp_loopback_buf: RTL and testbench

- Sits directly downstream of the eth UDP receive interface and upstream of its UDP transmit interface.
- Captures one received UDP payload into a single on-chip frame buffer.
- When the Ethernet transmitter is idle, requests transmission and returns the payload byte-for-byte, so the board echoes UDP datagrams to the host.
- Runs entirely in the GMII clock domain. Frames arriving while the buffer is occupied are dropped and counted.

---
 rtl/eth_pkg.sv | 20 ++
 rtl/udp_loopback_buf_if.sv | 32 +++
 rtl/udp_sdp_ram.sv | 26 ++
 rtl/udp_loopback_buf.sv | 175 +++++++++++++++++
 tb/tb_udp_loopback_buf.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the UDP loopback buffer: state encoding,
// payload limits and a saturating counter helper.
package eth_pkg;

    localparam int unsigned UDP_LEN_W = 16;
    localparam logic [UDP_LEN_W-1:0] UDP_MAX_PAYLOAD = 16'd1472;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RX      = 2'd1,
        WAIT_TX = 2'd2,
        TX      = 2'd3
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [UDP_LEN_W-1:0] sat_inc(input logic [UDP_LEN_W-1:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/udp_loopback_buf_if.sv
// UDP receive/transmit handshake plus status signals of the loopback buffer.
// slave: the buffer itself; master: the Ethernet side driving it.
interface udp_loopback_buf_if;

    logic                           udp_rx_data_vld;
    logic [7:0]                     udp_rx_data;
    logic                           udp_rx_done;
    logic [eth_pkg::UDP_LEN_W-1:0]  udp_rx_data_num;
    logic                           tx_rdy;
    logic                           udp_tx_req;
    logic                           udp_tx_en;
    logic [7:0]                     udp_tx_data;
    logic [eth_pkg::UDP_LEN_W-1:0]  udp_tx_data_num;
    logic                           busy;
    logic [15:0]                    drop_cnt;
    logic                           len_err;

    modport slave (
        input  udp_rx_data_vld, udp_rx_data, udp_rx_done, udp_rx_data_num,
        input  tx_rdy, udp_tx_req,
        output udp_tx_en, udp_tx_data, udp_tx_data_num,
        output busy, drop_cnt, len_err
    );

    modport master (
        output udp_rx_data_vld, udp_rx_data, udp_rx_done, udp_rx_data_num,
        output tx_rdy, udp_tx_req,
        input  udp_tx_en, udp_tx_data, udp_tx_data_num,
        input  busy, drop_cnt, len_err
    );

endinterface

// File: rtl/udp_sdp_ram.sv
// Simple dual-port byte RAM: synchronous write, registered read (1-cycle latency).
module udp_sdp_ram #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    // Write port and registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/udp_loopback_buf.sv
// Captures one received UDP payload and echoes it back once the Ethernet
// transmitter is idle. Frames arriving while the buffer is occupied, or
// longer than MAX_LEN, are dropped and counted.
module udp_loopback_buf
    import eth_pkg::*;
#(
    parameter int unsigned          ADDR_W  = 11,
    parameter logic [UDP_LEN_W-1:0] MAX_LEN = UDP_MAX_PAYLOAD
) (
    input  logic                clk,
    input  logic                rst_n,
    udp_loopback_buf_if.slave   bus
);

    state_e               state_q, state_d;
    logic [UDP_LEN_W-1:0] cnt_q, cnt_d;
    logic [UDP_LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [UDP_LEN_W-1:0] len_q, len_d;
    logic [15:0]          drop_q, drop_d;
    logic                 ovf_q, ovf_d;
    logic                 len_err_q, len_err_d;
    logic                 rd_vld_q, rd_vld_d;

    logic                 drop_inc;
    logic                 room;
    logic [UDP_LEN_W-1:0] rx_count;
    logic                 tx_en;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [7:0]           ram_rdata;

    assign room = (cnt_q < MAX_LEN);

    udp_sdp_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (bus.udp_rx_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // State register and all datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            len_q     <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
            len_err_q <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            len_q     <= len_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
            len_err_q <= len_err_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    // Next-state, buffer write/read control and drop accounting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_ptr_d  = rd_ptr_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        len_err_d = len_err_q;
        rd_vld_d  = 1'b0;
        drop_inc  = 1'b0;
        rx_count  = cnt_q;
        tx_en     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = cnt_q[ADDR_W-1:0];
        rd_en     = 1'b0;
        rd_addr   = rd_ptr_q[ADDR_W-1:0];

        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                ovf_d    = 1'b0;
                rd_ptr_d = '0;
                if (bus.udp_rx_data_vld) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    cnt_d   = 16'd1;
                    state_d = RX;
                    // A single-byte datagram ends in the same cycle it starts.
                    if (bus.udp_rx_done) begin
                        len_d   = 16'd1;
                        cnt_d   = '0;
                        state_d = WAIT_TX;
                        if (bus.udp_rx_data_num != 16'd1) begin
                            len_err_d = 1'b1;
                        end
                    end
                end
            end

            RX: begin
                if (bus.udp_rx_data_vld) begin
                    if (room) begin
                        wr_en    = 1'b1;
                        cnt_d    = cnt_q + 16'd1;
                        rx_count = cnt_q + 16'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (bus.udp_rx_done) begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    if (ovf_q || (bus.udp_rx_data_vld && !room)) begin
                        drop_inc = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        len_d   = rx_count;
                        state_d = WAIT_TX;
                        if (rx_count != bus.udp_rx_data_num) begin
                            len_err_d = 1'b1;
                        end
                    end
                end
            end

            WAIT_TX: begin
                rd_ptr_d = '0;
                if (bus.udp_rx_done) begin
                    drop_inc = 1'b1;
                end
                if (bus.tx_rdy) begin
                    tx_en   = 1'b1;
                    state_d = TX;
                end
            end

            TX: begin
                if (bus.udp_rx_done) begin
                    drop_inc = 1'b1;
                end
                if (bus.udp_tx_req && (rd_ptr_q < len_q)) begin
                    rd_en    = 1'b1;
                    rd_vld_d = 1'b1;
                    rd_ptr_d = rd_ptr_q + 16'd1;
                    if (rd_ptr_q == len_q - 16'd1) begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        drop_d = drop_inc ? sat_inc(drop_q) : drop_q;
    end

    // Reads outside a valid TX request return zero rather than stale RAM data.
    assign bus.udp_tx_data     = rd_vld_q ? ram_rdata : 8'h00;
    assign bus.udp_tx_en       = tx_en;
    assign bus.busy            = (state_q == WAIT_TX) || (state_q == TX);
    assign bus.udp_tx_data_num = bus.busy ? len_q : '0;
    assign bus.drop_cnt        = drop_q;
    assign bus.len_err         = len_err_q;

endmodule

// File: tb/tb_udp_loopback_buf.sv
// Directed bench for udp_loopback_buf: a table of echo frames plus
// hand-written sequences for drops, oversize frames and mid-frame reset.
module tb_udp_loopback_buf;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    udp_loopback_buf_if bus ();

    udp_loopback_buf #(
        .ADDR_W  (11),
        .MAX_LEN (16'd1472)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors   = 0;
    int checks   = 0;
    int exp_drop = 0;
    logic exp_lerr = 1'b0;
    int en_count = 0;

    typedef struct {
        int         len;
        int         num;
        logic [7:0] base;
        logic [7:0] step;
        int         rdy_delay;
        int         extra;
        logic       lerr;
    } vec_t;

    vec_t vecs[5];

    // Counts udp_tx_en pulses, sampled mid-cycle.
    always begin
        @(negedge clk);
        #2;
        if (bus.udp_tx_en === 1'b1) en_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [7:0] base, input logic [7:0] step, input int i);
        int v;
        v = int'(base) + int'(step) * i;
        return v[7:0];
    endfunction

    task automatic drive_rx(input logic vld, input logic [7:0] d, input logic done, input logic [15:0] num);
        bus.udp_rx_data_vld = vld;
        bus.udp_rx_data     = d;
        bus.udp_rx_done     = done;
        bus.udp_rx_data_num = num;
    endtask

    // Ends on the negedge after the posedge that consumed the last byte.
    task automatic send_frame(input int n, input int num, input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_rx(1'b1, pat(base, step, i), (i == n - 1), 16'(num));
        end
        @(negedge clk);
        drive_rx(1'b0, 8'h00, 1'b0, 16'h0);
    endtask

    task automatic echo(input int len, input logic [7:0] base, input logic [7:0] step,
                        input int rdy_delay, input int extra);
        int pulses;
        int waited;
        pulses = 0;
        waited = 0;
        bus.tx_rdy = 1'b0;
        for (int c = 0; c < rdy_delay; c++) begin
            #1;
            if (bus.udp_tx_en === 1'b1) pulses++;
            @(negedge clk);
        end
        chk("tx_en_while_not_rdy", pulses, 0);
        bus.tx_rdy = 1'b1;
        #1;
        while (bus.udp_tx_en !== 1'b1 && waited < 16) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("tx_en_first_rdy_cycle", waited, 0);
        if (bus.udp_tx_en !== 1'b1) begin
            bus.tx_rdy = 1'b0;
            return;
        end
        chk("tx_data_num", bus.udp_tx_data_num, len);
        chk("busy_wait_tx", bus.busy, 1);
        @(negedge clk);
        #1;
        chk("tx_en_single_pulse", bus.udp_tx_en, 0);
        bus.tx_rdy     = 1'b0;
        bus.udp_tx_req = 1'b1;
        for (int k = 0; k < len + extra; k++) begin
            @(negedge clk);
            chk("tx_data", bus.udp_tx_data, (k < len) ? pat(base, step, k) : 8'h00);
            if (k == len - 2) chk("busy_before_last", bus.busy, 1);
            if (k == len - 1) chk("busy_after_last", bus.busy, 0);
        end
        bus.udp_tx_req = 1'b0;
        chk("len_err", bus.len_err, exp_lerr);
    endtask

    task automatic check_reset_outputs();
        chk("rst_tx_en", bus.udp_tx_en, 0);
        chk("rst_tx_data", bus.udp_tx_data, 0);
        chk("rst_tx_data_num", bus.udp_tx_data_num, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_drop_cnt", bus.drop_cnt, 0);
        chk("rst_len_err", bus.len_err, 0);
    endtask

    initial begin
        int c0;

        vecs[0] = '{len: 4,    num: 4,    base: 8'h11, step: 8'h11, rdy_delay: 0,  extra: 0, lerr: 1'b0};
        vecs[1] = '{len: 5,    num: 5,    base: 8'hA0, step: 8'h03, rdy_delay: 20, extra: 0, lerr: 1'b0};
        vecs[2] = '{len: 1,    num: 1,    base: 8'h5A, step: 8'h00, rdy_delay: 2,  extra: 1, lerr: 1'b0};
        vecs[3] = '{len: 1472, num: 1472, base: 8'h00, step: 8'h01, rdy_delay: 0,  extra: 0, lerr: 1'b0};
        vecs[4] = '{len: 6,    num: 5,    base: 8'hC1, step: 8'h07, rdy_delay: 0,  extra: 1, lerr: 1'b1};

        drive_rx(1'b0, 8'h00, 1'b0, 16'h0);
        bus.tx_rdy     = 1'b0;
        bus.udp_tx_req = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven echo frames
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].len, vecs[v].num, vecs[v].base, vecs[v].step);
            if (vecs[v].lerr) exp_lerr = 1'b1;
            echo(vecs[v].len, vecs[v].base, vecs[v].step, vecs[v].rdy_delay, vecs[v].extra);
            chk("drop_cnt_vec", bus.drop_cnt, exp_drop);
            repeat (2) @(negedge clk);
        end

        // Stray rx_done in IDLE is neither counted nor transmitted
        bus.tx_rdy = 1'b1;
        c0 = en_count;
        drive_rx(1'b0, 8'h00, 1'b1, 16'd7);
        @(negedge clk);
        drive_rx(1'b0, 8'h00, 1'b0, 16'h0);
        repeat (5) @(negedge clk);
        chk("idle_done_drop_cnt", bus.drop_cnt, exp_drop);
        chk("idle_done_no_tx_en", en_count - c0, 0);
        chk("idle_done_busy", bus.busy, 0);
        bus.tx_rdy = 1'b0;

        // Second frame arriving during TX of a 100-byte frame is dropped
        send_frame(100, 100, 8'h01, 8'h01);
        bus.tx_rdy = 1'b1;
        #1;
        chk("ovl_tx_en", bus.udp_tx_en, 1);
        chk("ovl_tx_data_num", bus.udp_tx_data_num, 100);
        @(negedge clk);
        bus.tx_rdy     = 1'b0;
        bus.udp_tx_req = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (k >= 10 && k < 18) drive_rx(1'b1, 8'hE0 + 8'(k), (k == 17), 16'd8);
            else                   drive_rx(1'b0, 8'h00, 1'b0, 16'h0);
            @(negedge clk);
            chk("ovl_tx_data", bus.udp_tx_data, pat(8'h01, 8'h01, k));
        end
        bus.udp_tx_req = 1'b0;
        drive_rx(1'b0, 8'h00, 1'b0, 16'h0);
        exp_drop++;
        chk("ovl_drop_cnt", bus.drop_cnt, exp_drop);
        chk("ovl_busy", bus.busy, 0);
        bus.tx_rdy = 1'b1;
        c0 = en_count;
        repeat (10) @(negedge clk);
        chk("ovl_second_not_sent", en_count - c0, 0);
        bus.tx_rdy = 1'b0;

        // Oversize frame is dropped without a transmit, next frame is fine
        bus.tx_rdy = 1'b1;
        c0 = en_count;
        send_frame(1500, 1500, 8'h00, 8'h01);
        repeat (10) @(negedge clk);
        exp_drop++;
        chk("big_no_tx_en", en_count - c0, 0);
        chk("big_drop_cnt", bus.drop_cnt, exp_drop);
        chk("big_busy", bus.busy, 0);
        bus.tx_rdy = 1'b0;
        send_frame(10, 10, 8'h30, 8'h01);
        echo(10, 8'h30, 8'h01, 0, 0);
        chk("after_big_drop_cnt", bus.drop_cnt, exp_drop);

        // Reset asserted mid-RX aborts the frame
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_rx(1'b1, 8'h70 + 8'(i), 1'b0, 16'h0);
        end
        @(negedge clk);
        drive_rx(1'b0, 8'h00, 1'b0, 16'h0);
        rst_n      = 1'b0;
        bus.tx_rdy = 1'b1;
        exp_drop   = 0;
        exp_lerr   = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c0 = en_count;
        repeat (10) @(negedge clk);
        chk("post_rst_no_tx_en", en_count - c0, 0);
        chk("post_rst_busy", bus.busy, 0);
        bus.tx_rdy = 1'b0;
        send_frame(2, 2, 8'hB5, 8'h10);
        echo(2, 8'hB5, 8'h10, 1, 0);
        chk("post_rst_drop_cnt", bus.drop_cnt, exp_drop);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
